// File: rtl/c7bexu_rf_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : c7bexu_rf_mp_if
// Description : Bus bundle for the c7bexu multi-port register file. It carries
//               the write, allocate and read ports, the flush strobe and the
//               ready indication.
// Revision    : 1.0 - initial release
// ============================================================================
interface c7bexu_rf_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NW = 2,
    parameter int NR = 6
);
    logic               ready;
    logic               flush;
    logic [NW-1:0]      wen;
    logic [NW*AW-1:0]   waddr;
    logic [NW*DW-1:0]   wdata;
    logic [NW-1:0]      alloc_en;
    logic [NW*AW-1:0]   alloc_addr;
    logic [NR*AW-1:0]   raddr;
    logic [NR*DW-1:0]   rdata;
    logic [NR-1:0]      rpend;

    // Issue / execute side drives the request signals
    modport master (
        input  ready, rdata, rpend,
        output flush, wen, waddr, wdata, alloc_en, alloc_addr, raddr
    );

    // Register file side
    modport slave (
        output ready, rdata, rpend,
        input  flush, wen, waddr, wdata, alloc_en, alloc_addr, raddr
    );
endinterface
`default_nettype wire

// File: rtl/c7bexu_rf_mp.sv
`default_nettype none
// ============================================================================
// Module      : c7bexu_rf_mp
// Description : Parametrised multi-port register file with per-register
//               pending scoreboard, optional zero register, optional
//               same-cycle write forwarding and a post-reset zeroing sweep
//               that clears the (unreset) storage array one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module c7bexu_rf_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NW       = 2,
    parameter int NR       = 6,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    c7bexu_rf_mp_if.slave    bus
);
    localparam int NREG = 1 << AW;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [NREG-1:0]    pend_q, pend_d;
    logic [DW-1:0]      mem_q [NREG];

    // Per-entry resolved write / allocate requests (highest port wins)
    logic [NREG-1:0]    wr_hit;
    logic [DW-1:0]      wr_data [NREG];
    logic [NREG-1:0]    al_hit;

    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_val;
    logic               rd_pend;

    // Sweep controller: state and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep controller: walk every entry once, then run forever
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Resolve write and allocate ports per entry; ascending scan lets the
    // highest-index matching port win
    always_comb begin
        wr_hit = '0;
        al_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_data[r] = '0;
            for (int p = 0; p < NW; p++) begin
                if (bus.wen[p] && (bus.waddr[p*AW +: AW] == AW'(r))) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = bus.wdata[p*DW +: DW];
                end
                if (bus.alloc_en[p] && (bus.alloc_addr[p*AW +: AW] == AW'(r))) begin
                    al_hit[r] = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0) begin
            wr_hit[0] = 1'b0;
            al_hit[0] = 1'b0;
        end
    end

    // Storage array: zeroed by the sweep, written only in RUN
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NREG; r++) begin
            if (state_q == ST_INIT) begin
                if (cnt_q == AW'(r)) begin
                    mem_q[r] <= '0;
                end
            end else if (wr_hit[r]) begin
                mem_q[r] <= wr_data[r];
            end
        end
    end

    // Scoreboard next state: flush > alloc set > write clear
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_RUN) begin
            if (bus.flush) begin
                pend_d = '0;
            end else begin
                for (int r = 0; r < NREG; r++) begin
                    if (al_hit[r]) begin
                        pend_d[r] = 1'b1;
                    end else if (wr_hit[r]) begin
                        pend_d[r] = 1'b0;
                    end
                end
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read ports: zero register, then forwarding, then array; all quiet
    // until the sweep has finished
    always_comb begin
        bus.rdata = '0;
        bus.rpend = '0;
        rd_addr   = '0;
        rd_val    = '0;
        rd_pend   = 1'b0;
        for (int j = 0; j < NR; j++) begin
            rd_addr = bus.raddr[j*AW +: AW];
            rd_val  = mem_q[rd_addr];
            rd_pend = pend_q[rd_addr];
            if ((BYPASS != 0) && wr_hit[rd_addr]) begin
                rd_val  = wr_data[rd_addr];
                rd_pend = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_val  = '0;
                rd_pend = 1'b0;
            end
            if (state_q != ST_RUN) begin
                rd_val  = '0;
                rd_pend = 1'b0;
            end
            bus.rdata[j*DW +: DW] = rd_val;
            bus.rpend[j]          = rd_pend;
        end
    end

    assign bus.ready = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: doc/c7bexu_rf_mp.md
Name: c7bexu_rf_mp

Overview:
Parametrised multi-port register file for the c7bexu execution unit. It generalises the fixed 2-write/6-read, 32x32 file to configurable width, depth and port counts. It adds a per-register scoreboard (pending bits) so issue logic can detect outstanding writers. A post-reset zeroing sequencer clears the array one entry per cycle, so the storage array needs no reset.

Parameters:
DW, 32, data width in bits
AW, 5, address width; NREG = 2**AW entries
NW, 2, number of write ports (and allocate ports)
NR, 6, number of read ports
ZERO_REG, 1, 1 = entry 0 always reads 0, is never written and is never pending
BYPASS, 1, 1 = same-cycle write-to-read forwarding on data and pending

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ready  out  1  high once the zeroing sweep is complete
flush  in  1  clears every pending bit
wen  in  NW  per-port write enable
waddr  in  NW*AW  write addresses; port i at [i*AW +: AW]
wdata  in  NW*DW  write data; port i at [i*DW +: DW]
alloc_en  in  NW  per-port scoreboard set enable
alloc_addr  in  NW*AW  registers to mark pending
raddr  in  NR*AW  read addresses
rdata  out  NR*DW  read data, combinational
rpend  out  NR  pending bit of each read address, combinational

Behaviour:
- Reset (rst=0, asynchronous): state=INIT, sweep counter=0, pending all 0, ready=0. While ready=0, rdata and rpend read 0.
- The storage array has no reset. It is cleared only by the sweep.
- INIT state: each cycle writes 0 to entry[counter], then the counter increments.
  - After entry NREG-1 is written, state moves to RUN. ready=1 from the next cycle.
  - The sweep takes exactly NREG cycles after reset deassertion.
  - If rst asserts mid-sweep, the sweep restarts from 0.
- In INIT, wen, alloc_en and flush are ignored.
- RUN state is permanent until the next reset.
- Writes (RUN):
  - entry[waddr_i] <= wdata_i when wen_i=1.
  - If several enabled ports target one address, the highest-index port wins. Lower ports to that address are suppressed.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Reads:
  - rdata_j = 0 if ZERO_REG and raddr_j==0.
  - Else, with BYPASS=1, a same-cycle enabled write to raddr_j forwards its wdata; the highest-index matching port wins.
  - Otherwise rdata_j = entry[raddr_j].
  - With BYPASS=0, reads see array contents only; the written value is visible next cycle.
- Scoreboard (RUN), next-state per entry r:
  - Cleared if any enabled write targets r.
  - Set if any enabled alloc targets r.
  - Set beats clear in the same cycle (a new writer was issued).
  - flush=1 zeroes all entries and beats both set and clear.
  - Entry 0 is never set when ZERO_REG=1.
- rpend_j = pending[raddr_j], with these overrides:
  - With BYPASS=1, forced 0 if a same-cycle enabled write targets raddr_j.
  - Always 0 for address 0 when ZERO_REG=1.
  - Alloc does not bypass into rpend; it is visible next cycle.
- Latency: write to array readout is 1 cycle (0 with bypass). Alloc to rpend is 1 cycle. Write clear to rpend is 1 cycle (0 with bypass).
- Width rules: all ports flattened little-end first (port 0 in the LSBs). Addresses are compared at full AW bits.

Test Plan:
- Reset sweep (defaults): release rst, hold wen=1 to addr 3 with data 0xDEAD -> ready rises exactly 32 cycles after release; all 6 rdata read 0 for every address; entry 3 reads 0 (the write was ignored).
- Write conflict: RUN, wen=2'b11, waddr both 7, wdata0=0x11, wdata1=0x22 -> same-cycle read of r7 returns 0x22; next cycle array holds 0x22.
- Bypass and zero register: write 0x5 to r0 and 0xA5A5 to r9 while reading r0 and r9 -> 0 and 0xA5A5 same cycle; r0 stays 0. Rerun with BYPASS=0 -> r9 returns old value, then 0xA5A5 next cycle.
- Scoreboard: alloc r12 -> rpend=1 next cycle. Next, alloc r12 and write r12 together -> stays 1. Then write r12 alone -> rpend 0 in the same cycle (bypass) and 0 thereafter.
- Flush priority: pending on r4 and r5; assert flush with alloc r6 the same cycle -> all rpend 0 next cycle, r6 not pending.
- Reset mid-sweep: assert rst at sweep cycle 10, release -> ready rises a full NREG cycles after the second release. Repeat with AW=3, NW=3, NR=4 -> ready after 8 cycles; 3-way write conflict resolves to port 2.
